// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the PC, reads 16-bit words from
//             a combinational-read instruction memory and assembles 32-bit
//             instructions (one-word, or opcode word + immediate word) for
//             the IF/ID pipeline buffer. The start PC is loaded from a
//             two-word reset vector (high half first).
//  Ports    : clk, rst_n             clock / async active-low reset
//             imem_addr, imem_rdata  instruction-memory word address / data
//             fetch_stall            hold all state
//             redirect, redirect_pc  branch/ret target load
//             fetch_instruction      {first_word, second_word}
//             fetch_pc               address of the instruction's first word
//             fetch_valid            fetch_instruction is a real instruction
//             fetch_count            (FETCH_CNT_EN only) accepted fetches
//  Options  : `define FETCH_CNT_EN adds the fetch_count port and counter.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter int ADDR_W    = 20,
   parameter int RESET_VEC = 0,
   parameter int IMM_BIT   = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              fetch_stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic [31:0]       fetch_instruction,
   output logic [31:0]       fetch_pc,
   output logic              fetch_valid
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0]       fetch_count
`endif
);

   typedef enum logic [1:0] {
      VEC_HI    = 2'd0,
      VEC_LO    = 2'd1,
      FETCH     = 2'd2,
      FETCH_IMM = 2'd3
   } state_t;

   // Vector addresses are taken modulo the memory size, so RESET_VEC+1 wraps.
   localparam logic [31:0]       c_vec32  = RESET_VEC;
   localparam logic [ADDR_W-1:0] c_vec_hi = c_vec32[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] c_vec_lo = c_vec_hi + {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t      r_state;
   logic [31:0] r_pc;
   logic [15:0] r_held_word;
   logic [31:0] r_held_pc;
   logic        w_is_imm;

   assign w_is_imm = imem_rdata[IMM_BIT];

   // Outputs are decoded combinationally from the current state and the
   // memory word, so they track an async reset without waiting for a clock.
   always_comb begin
      imem_addr         = r_pc[ADDR_W-1:0];
      fetch_instruction = 32'h0;
      fetch_pc          = 32'h0;
      fetch_valid       = 1'b0;
      case (r_state)
         VEC_HI: imem_addr = c_vec_hi;
         VEC_LO: imem_addr = c_vec_lo;
         FETCH: begin
            if (!w_is_imm) begin
               fetch_instruction = {imem_rdata, 16'h0};
               fetch_pc          = r_pc;
               fetch_valid       = 1'b1;
            end
         end
         FETCH_IMM: begin
            fetch_instruction = {r_held_word, imem_rdata};
            fetch_pc          = r_held_pc;
            fetch_valid       = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= VEC_HI;
         r_pc        <= 32'h0;
         r_held_word <= 16'h0;
         r_held_pc   <= 32'h0;
      end else begin
         case (r_state)
            // Vector load ignores stall and redirect: nothing downstream is
            // valid yet, so there is nothing to hold or flush.
            VEC_HI: begin
               r_pc[31:16] <= imem_rdata;
               r_state     <= VEC_LO;
            end
            VEC_LO: begin
               r_pc[15:0] <= imem_rdata;
               r_state    <= FETCH;
            end
            FETCH, FETCH_IMM: begin
               if (redirect) begin
                  // Redirect beats stall; any half-assembled instruction is dropped.
                  r_pc        <= redirect_pc;
                  r_state     <= FETCH;
                  r_held_word <= 16'h0;
               end else if (!fetch_stall) begin
                  r_pc <= r_pc + 32'd1;
                  if (r_state == FETCH && w_is_imm) begin
                     r_held_word <= imem_rdata;
                     r_held_pc   <= r_pc;
                     r_state     <= FETCH_IMM;
                  end else begin
                     r_state <= FETCH;
                  end
               end
            end
            default: r_state <= VEC_HI;
         endcase
      end
   end

`ifdef FETCH_CNT_EN
   // Counts only instructions the IF/ID buffer actually accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= 32'h0;
      end else if (fetch_valid && !fetch_stall && !redirect) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: directed reset-vector,
//             one-word, two-word, stall, redirect and async-reset scenarios,
//             plus randomized stall/redirect traffic checked against an
//             instruction-stream reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   localparam int ADDR_W = 20;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_rdata;
   logic              fetch_stall;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic [31:0]       fetch_instruction;
   logic [31:0]       fetch_pc;
   logic              fetch_valid;
`ifdef FETCH_CNT_EN
   logic [31:0]       fetch_count;
`endif

   logic [15:0] mem [0:4095];
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[11:0]];

   fetch_unit #(.ADDR_W(ADDR_W), .RESET_VEC(0), .IMM_BIT(15)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem_addr         (imem_addr),
      .imem_rdata        (imem_rdata),
      .fetch_stall       (fetch_stall),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .fetch_instruction (fetch_instruction),
      .fetch_pc          (fetch_pc),
      .fetch_valid       (fetch_valid)
`ifdef FETCH_CNT_EN
      ,
      .fetch_count       (fetch_count)
`endif
   );

   // Reference model: the instruction that starts at word address a.
   function automatic logic [31:0] exp_instr(input logic [31:0] a);
      logic [31:0] a1;
      logic [15:0] w;
      a1 = a + 32'd1;
      w  = mem[a[11:0]];
      if (w[15]) return {w, mem[a1[11:0]]};
      return {w, 16'h0};
   endfunction

   function automatic int exp_len(input logic [31:0] a);
      logic [15:0] w;
      w = mem[a[11:0]];
      return w[15] ? 2 : 1;
   endfunction

   // Reset, release, and step through both vector cycles into FETCH.
   task automatic go_fetch();
      fetch_stall = 1'b0;
      redirect    = 1'b0;
      rst_n       = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      mem[0] = 16'h0000; mem[1] = 16'h0010; mem[16'h10] = 16'h1234;
      rst_n = 1'b0; fetch_stall = 1'b0; redirect = 1'b0;
      #1;
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid got %h want 0", fetch_valid); else n_pass++;
      n_checks++; if (fetch_instruction !== 32'h0) $display("FAIL reset_instr got %h want 0", fetch_instruction); else n_pass++;
      n_checks++; if (fetch_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", fetch_pc); else n_pass++;
`ifdef FETCH_CNT_EN
      n_checks++; if (fetch_count !== 32'h0) $display("FAIL reset_count got %h want 0", fetch_count); else n_pass++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (imem_addr !== 20'h0) $display("FAIL vec_hi_addr got %h want 0", imem_addr); else n_pass++;
      @(negedge clk);
      n_checks++; if (imem_addr !== 20'h1) $display("FAIL vec_lo_addr got %h want 1", imem_addr); else n_pass++;
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL vec_lo_valid got %h want 0", fetch_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (imem_addr !== 20'h10) $display("FAIL first_addr got %h want 10", imem_addr); else n_pass++;
      n_checks++; if (fetch_valid !== 1'b1) $display("FAIL first_valid got %h want 1", fetch_valid); else n_pass++;
      n_checks++; if (fetch_pc !== 32'h10) $display("FAIL first_pc got %h want 10", fetch_pc); else n_pass++;
   endtask

   task automatic test_one_word();
      logic [31:0] want_i [3];
      want_i[0] = 32'h12340000; want_i[1] = 32'h23450000; want_i[2] = 32'h34560000;
      mem[16'h10] = 16'h1234; mem[16'h11] = 16'h2345; mem[16'h12] = 16'h3456;
      go_fetch();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (fetch_instruction !== want_i[i] || fetch_valid !== 1'b1)
            $display("FAIL one_word_%0d got %h/%b want %h/1", i, fetch_instruction, fetch_valid, want_i[i]); else n_pass++;
         n_checks++; if (fetch_pc !== 32'h10 + i) $display("FAIL one_word_pc_%0d got %h want %h", i, fetch_pc, 32'h10 + i); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_two_word();
      mem[16'h10] = 16'h8001; mem[16'h11] = 16'hBEEF; mem[16'h12] = 16'h0042;
      go_fetch();
      n_checks++; if (fetch_valid !== 1'b0 || fetch_instruction !== 32'h0)
         $display("FAIL two_word_bubble got %h/%b want 0/0", fetch_instruction, fetch_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (fetch_instruction !== 32'h8001BEEF || fetch_valid !== 1'b1)
         $display("FAIL two_word_instr got %h/%b want 8001beef/1", fetch_instruction, fetch_valid); else n_pass++;
      n_checks++; if (fetch_pc !== 32'h10) $display("FAIL two_word_pc got %h want 10", fetch_pc); else n_pass++;
      @(negedge clk);
      n_checks++; if (imem_addr !== 20'h12 || fetch_instruction !== 32'h00420000)
         $display("FAIL two_word_next got %h/%h want 12/00420000", imem_addr, fetch_instruction); else n_pass++;
   endtask

   task automatic test_stall();
      go_fetch();
      @(negedge clk);
      fetch_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (fetch_instruction !== 32'h8001BEEF || fetch_pc !== 32'h10 || imem_addr !== 20'h11 || fetch_valid !== 1'b1)
            $display("FAIL stall_hold_%0d got %h/%h/%h want 8001beef/10/11", i, fetch_instruction, fetch_pc, imem_addr); else n_pass++;
      end
      fetch_stall = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_addr !== 20'h12 || fetch_instruction !== 32'h00420000 || fetch_pc !== 32'h12)
         $display("FAIL stall_resume got %h/%h/%h want 12/00420000/12", imem_addr, fetch_instruction, fetch_pc); else n_pass++;
   endtask

   task automatic test_redirect_stall();
      mem[16'h40] = 16'h0777; mem[16'h41] = 16'h0778;
      go_fetch();
      @(negedge clk);
      fetch_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      fetch_stall = 1'b0; redirect = 1'b0;
      n_checks++; if (imem_addr !== 20'h40 || fetch_instruction !== 32'h07770000 || fetch_pc !== 32'h40 || fetch_valid !== 1'b1)
         $display("FAIL redirect_target got %h/%h/%h want 40/07770000/40", imem_addr, fetch_instruction, fetch_pc); else n_pass++;
      @(negedge clk);
      n_checks++; if (fetch_instruction[31:16] === 16'h8001 || fetch_instruction !== 32'h07780000)
         $display("FAIL redirect_no_stale got %h want 07780000", fetch_instruction); else n_pass++;
   endtask

   task automatic test_async_reset();
      bit found = 1'b0;
      for (int i = 16'h10; i < 16'h30; i++) mem[i] = 16'($urandom_range(0, 16'h7FFF));
      go_fetch();
      for (int i = 0; i < 40 && !found; i++) begin
         if (imem_addr == 20'h25) found = 1'b1; else @(negedge clk);
      end
      n_checks++; if (!found) $display("FAIL async_reach_25 got %h want 25", imem_addr); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (fetch_valid !== 1'b0 || fetch_instruction !== 32'h0 || imem_addr !== 20'h0)
         $display("FAIL async_reset_now got %b/%h/%h want 0/0/0", fetch_valid, fetch_instruction, imem_addr); else n_pass++;
`ifdef FETCH_CNT_EN
      n_checks++; if (fetch_count !== 32'h0) $display("FAIL async_count_clear got %h want 0", fetch_count); else n_pass++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (imem_addr !== 20'h1) $display("FAIL async_vec_lo got %h want 1", imem_addr); else n_pass++;
      @(negedge clk);
      n_checks++; if (imem_addr !== 20'h10 || fetch_pc !== 32'h10 || fetch_valid !== 1'b1)
         $display("FAIL async_reload got %h/%h want 10/10", imem_addr, fetch_pc); else n_pass++;
`ifdef FETCH_CNT_EN
      repeat (5) @(negedge clk);
      n_checks++; if (fetch_count !== 32'd5) $display("FAIL count_after_5 got %0d want 5", fetch_count); else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] p = 32'h200;
      int          want_cycles = 0;
      int          cycles = 0;
      int          accepted = 0;
      mem[0] = 16'h0000; mem[1] = 16'h0200;
      go_fetch();
      while (accepted < 20 && cycles < 100) begin
         cycles++;
         if (fetch_valid) begin
            n_checks++; if (fetch_instruction !== exp_instr(p) || fetch_pc !== p)
               $display("FAIL b2b_%0d got %h@%h want %h@%h", accepted, fetch_instruction, fetch_pc, exp_instr(p), p); else n_pass++;
            want_cycles += exp_len(p);
            p += 32'(exp_len(p));
            accepted++;
         end
         if (accepted < 20) @(negedge clk);
      end
      n_checks++; if (cycles !== want_cycles) $display("FAIL b2b_throughput got %0d want %0d", cycles, want_cycles); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] p = 32'h100;
      logic [31:0] target;
      bit          st, rd;
      int          accepted = 0;
      mem[0] = 16'h0000; mem[1] = 16'h0100;
      go_fetch();
      for (int cyc = 0; cyc < 500; cyc++) begin
         st     = ($urandom % 4) == 0;
         rd     = ($urandom % 16) == 0;
         target = $urandom_range(16'h100, 16'hE00);
         if (!fetch_valid) begin
            n_checks++; if (fetch_instruction !== 32'h0) $display("FAIL rnd_nop_%0d got %h want 0", cyc, fetch_instruction); else n_pass++;
         end else if (!st && !rd) begin
            n_checks++; if (fetch_instruction !== exp_instr(p) || fetch_pc !== p)
               $display("FAIL rnd_%0d got %h@%h want %h@%h", cyc, fetch_instruction, fetch_pc, exp_instr(p), p); else n_pass++;
            p += 32'(exp_len(p));
            accepted++;
         end
         if (rd) p = target;
         fetch_stall = st; redirect = rd; redirect_pc = target;
         @(negedge clk);
      end
      fetch_stall = 1'b0; redirect = 1'b0;
      n_checks++; if (accepted < 100) $display("FAIL rnd_progress got %0d want >=100", accepted); else n_pass++;
`ifdef FETCH_CNT_EN
      n_checks++; if (fetch_count !== 32'(accepted)) $display("FAIL rnd_count got %0d want %0d", fetch_count, accepted); else n_pass++;
`endif
   endtask

   initial begin
      rst_n = 1'b0; fetch_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
      @(negedge clk);
      test_reset();
      test_one_word();
      test_two_word();
      test_stall();
      test_redirect_stall();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
